// File: rtl/data_sync_filt.sv
// Multi-channel async-input synchroniser with a per-bit stability filter and edge strobes.
// Latency STAGES+FILT_CNT-1 edges from first capture; no backpressure, every output is a flop.
module data_sync_filt #(
  parameter int               WIDTH    = 1,
  parameter int               STAGES   = 2,
  parameter int               FILT_CNT = 1,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int            CW   = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_CNT - 1);

  // Element 0 is the capture flop; element STAGES-1 feeds the filter.
  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             w_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= {STAGES{INIT}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], data_i};
    end
  end

  assign w_s = r_sync[STAGES-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    logic          r_rise;
    logic          r_fall;

    // Counter only runs while the synchronised input disagrees with the output level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_cnt  <= '0;
        r_lvl  <= INIT[g];
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else if (w_s[g] == r_lvl) begin
        r_cnt  <= '0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_lvl  <= w_s[g];
        r_rise <= w_s[g];
        r_fall <= ~w_s[g];
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end
    end

    assign data_o[g] = r_lvl;
    assign rise_o[g] = r_rise;
    assign fall_o[g] = r_fall;
  end

endmodule

// File: tb/tb_data_sync_filt.sv
// Bench for data_sync_filt: vector table, directed filter/reset sequences and a randomized
// run scored against a history-based reference model.
module tb_data_sync_filt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // A: 4 channels, default depth, no filtering, non-zero reset value.
  logic       rst_a;
  logic [3:0] din_a, do_a, rise_a, fall_a;
  data_sync_filt #(.WIDTH(4), .STAGES(2), .FILT_CNT(1), .INIT(4'b1010)) u_a (
    .clk_i(clk), .rst_n_i(rst_a), .data_i(din_a),
    .data_o(do_a), .rise_o(rise_a), .fall_o(fall_a));

  // B: 2 channels, 3-deep chain, 4-cycle filter.
  logic       rst_b;
  logic [1:0] din_b, do_b, rise_b, fall_b;
  data_sync_filt #(.WIDTH(2), .STAGES(3), .FILT_CNT(4), .INIT(2'b00)) u_b (
    .clk_i(clk), .rst_n_i(rst_b), .data_i(din_b),
    .data_o(do_b), .rise_o(rise_b), .fall_o(fall_b));

  // C: 1 channel, 8-cycle filter, used for the mid-count reset.
  logic rst_c;
  logic din_c, do_c, rise_c, fall_c;
  data_sync_filt #(.WIDTH(1), .STAGES(2), .FILT_CNT(8), .INIT(1'b0)) u_c (
    .clk_i(clk), .rst_n_i(rst_c), .data_i(din_c),
    .data_o(do_c), .rise_o(rise_c), .fall_o(fall_c));

  // Reference model for B: s is the input captured STAGES edges ago; a bit flips once the
  // last FILT_CNT samples since its previous flip all disagree with its current level.
  localparam int BS = 3;
  localparam int BF = 4;
  logic [1:0] m_pipe[$];
  logic [1:0] m_hist[$];
  logic [1:0] m_do, m_rise, m_fall, m_s;
  int         m_since[2];
  bit         m_on, m_stable;

  initial begin
    m_on = 0; m_do = '0; m_rise = '0; m_fall = '0;
    forever begin
      @(posedge clk);
      if (!rst_b) begin
        m_pipe.delete();
        for (int i = 0; i < BS; i++) m_pipe.push_back(2'b00);
        m_hist.delete();
        m_do = '0; m_rise = '0; m_fall = '0;
        m_since[0] = 0; m_since[1] = 0;
        m_on = 0;
      end else begin
        m_s = m_pipe.pop_front();
        m_pipe.push_back(din_b);
        m_hist.push_back(m_s);
        if (m_hist.size() > BF) void'(m_hist.pop_front());
        m_rise = '0; m_fall = '0;
        for (int c = 0; c < 2; c++) begin
          m_since[c]++;
          m_stable = (m_hist.size() == BF) && (m_since[c] >= BF);
          foreach (m_hist[h]) if (m_hist[h][c] == m_do[c]) m_stable = 0;
          if (m_stable) begin
            m_do[c]    = ~m_do[c];
            m_rise[c]  = m_do[c];
            m_fall[c]  = ~m_do[c];
            m_since[c] = 0;
          end
        end
        m_on = 1;
      end
      @(negedge clk);
      if (m_on) begin
        chk("b_model", 32'({do_b, rise_b, fall_b}), 32'({m_do, m_rise, m_fall}));
        chk("b_excl", 32'(rise_b & fall_b), 32'd0);
      end
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;
  vec_t tbl[$];

  task automatic b_run(input string nm, input logic [31:0] pat, input int n,
                       input int rise_at, input int fall_at);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      din_b[0] = pat[j];
      @(posedge clk);
      #1;
      chk({nm, "_lvl"},  32'(do_b[0]),   32'(j >= rise_at && j < fall_at));
      chk({nm, "_rise"}, 32'(rise_b[0]), 32'(j == rise_at));
      chk({nm, "_fall"}, 32'(fall_b[0]), 32'(j == fall_at));
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    din_a = 4'b0000; din_b = 2'b00; din_c = 1'b0;

    // Each row is one clock edge; expected values are those after that edge.
    tbl.push_back('{1'b0, 4'b0000, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0, 4'b0101, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0, 4'b1111, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1011, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1011, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1011, 4'b1011, 4'b0001, 4'b0000});
    tbl.push_back('{1'b1, 4'b1011, 4'b1011, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1011, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1011, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0001});
    tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1011, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1011, 4'b1011, 4'b0001, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0001});
    tbl.push_back('{1'b1, 4'b1011, 4'b1011, 4'b0001, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0001});
    tbl.push_back('{1'b1, 4'b1010, 4'b1011, 4'b0001, 4'b0000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0001});
    tbl.push_back('{1'b1, 4'b1000, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1000, 4'b1010, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b0010});
    tbl.push_back('{1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b0000});

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_a = tbl[i].rst;
      din_a = tbl[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("a_vec%0d", i), 32'({do_a, rise_a, fall_a}),
          32'({tbl[i].dout, tbl[i].rise, tbl[i].fall}));
      chk($sformatf("a_excl%0d", i), 32'(rise_a & fall_a), 32'd0);
    end

    @(negedge clk);
    rst_b = 1'b1;
    repeat (6) @(negedge clk);
    b_run("b_pulse3",   32'h0000_0007, 12, 99, 99);
    b_run("b_pulse4",   32'h0000_000F, 14, 6, 10);
    b_run("b_restart",  32'h0000_01F7, 18, 10, 15);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, (i < 800) ? 3 : 7) == 0) din_b[c] = ~din_b[c];
    end

    @(negedge clk);
    rst_c = 1'b1;
    din_c = 1'b1;
    for (int j = 0; j < 11; j++) begin
      @(posedge clk);
      #1;
      chk("c_up_lvl",  32'(do_c),   32'(j >= 9));
      chk("c_up_rise", 32'(rise_c), 32'(j == 9));
      chk("c_up_fall", 32'(fall_c), 32'd0);
    end
    @(negedge clk);
    din_c = 1'b0;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk);
      #1;
      chk("c_cnt_hold", 32'({do_c, rise_c, fall_c}), 32'(3'b100));
    end
    #2;
    rst_c = 1'b0;
    din_c = 1'b1;
    #1;
    chk("c_async_rst", 32'({do_c, rise_c, fall_c}), 32'(3'b000));
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("c_in_rst", 32'({do_c, rise_c, fall_c}), 32'(3'b000));
    end
    @(negedge clk);
    rst_c = 1'b1;
    for (int j = 0; j < 11; j++) begin
      @(posedge clk);
      #1;
      chk("c_fresh_lvl",  32'(do_c),   32'(j >= 9));
      chk("c_fresh_rise", 32'(rise_c), 32'(j == 9));
      chk("c_fresh_fall", 32'(fall_c), 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
